// File: rtl/column_queue_admission_pkg.sv
// Shared constants and types for the per-column queue admission stage.
// Queue ID bit layout, shared with the crossbar and the shared-buffer
// controller: queue_id[4:2] = priority, queue_id[1:0] = destination port.
package column_queue_admission_pkg;

  localparam int QUEUE_ID_WIDTH    = 5;
  localparam int PRIO_WIDTH        = 3;
  localparam int DEST_WIDTH        = 2;
  localparam int QUEUE_NUM         = 32;
  localparam int QUEUE_CAP_DEFAULT = 64;
  localparam int OCC_WIDTH         = 7;
  localparam int DROP_CNT_WIDTH    = 16;

  typedef logic [QUEUE_ID_WIDTH-1:0] queue_id_t;
  typedef logic [OCC_WIDTH-1:0]      occ_t;
  typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

  typedef struct packed {
    logic [PRIO_WIDTH-1:0] prio;
    logic [DEST_WIDTH-1:0] dest;
  } queue_sel_t;

  // Net occupancy after one optional admit and one optional legal dequeue.
  function automatic occ_t occ_next(input occ_t cur, input logic inc, input logic dec);
    occ_t nxt;
    nxt = cur;
    if (inc && !dec) nxt = cur + occ_t'(1);
    if (dec && !inc) nxt = cur - occ_t'(1);
    return nxt;
  endfunction

  // Saturating increment for the drop counter.
  function automatic drop_cnt_t sat_inc(input drop_cnt_t cur);
    return (cur == '1) ? cur : cur + drop_cnt_t'(1);
  endfunction

endpackage

// File: rtl/column_queue_admission_ingress_fifo.sv
// Synchronous FIFO with first-word-fall-through head. Push when full and
// pop when empty are ignored. Storage is not reset; only pointers are.
module ingress_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head presented as zero while empty so the idle output is clean.
  assign dout = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/column_queue_admission.sv
// Per-column tail-drop admission: per-queue occupancy limits for 32 queues,
// an ingress FIFO toward the shared buffer, drop counting and underflow flag.
module column_queue_admission
  import column_queue_admission_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int QUEUE_CAP  = QUEUE_CAP_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [QUEUE_ID_WIDTH-1:0] i_cb_queue_sel,
  input  logic [DATA_WIDTH-1:0]     i_cb_din,
  input  logic                      i_cb_dat_valid,
  output logic                      o_wr_valid,
  output logic [QUEUE_ID_WIDTH-1:0] o_wr_queue_id,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  input  logic                      i_wr_ready,
  input  logic                      i_deq_valid,
  input  logic [QUEUE_ID_WIDTH-1:0] i_deq_queue_id,
  output logic [QUEUE_NUM-1:0]      o_queue_nonempty,
  output logic                      o_drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_cnt,
  output logic                      o_err_underflow
);

  localparam int   FIFO_W = QUEUE_ID_WIDTH + DATA_WIDTH;
  localparam occ_t CAP_C  = occ_t'(QUEUE_CAP);

  occ_t              occ_q [QUEUE_NUM];
  occ_t              occ_d [QUEUE_NUM];
  logic              drop_pulse_q, drop_pulse_d;
  drop_cnt_t         drop_cnt_q, drop_cnt_d;
  logic              underflow_q, underflow_d;

  logic              fifo_full, fifo_empty;
  logic              fifo_push, fifo_pop;
  logic [FIFO_W-1:0] fifo_din, fifo_dout;

  logic              admit, drop, deq_at_zero;

  // Admission is judged on registered occupancy and registered fullness,
  // so a same-cycle dequeue or pop never opens room for this strobe.
  assign admit       = i_cb_dat_valid && (occ_q[i_cb_queue_sel] < CAP_C) && !fifo_full;
  assign drop        = i_cb_dat_valid && !admit;
  assign deq_at_zero = i_deq_valid && (occ_q[i_deq_queue_id] == '0);

  assign fifo_push = admit;
  assign fifo_din  = {i_cb_queue_sel, i_cb_din};
  assign fifo_pop  = !fifo_empty && i_wr_ready;

  ingress_sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign o_wr_valid                   = !fifo_empty;
  assign {o_wr_queue_id, o_wr_data}   = fifo_dout;

  // Per-queue occupancy next-state: admit increments, a dequeue of a
  // nonzero counter decrements; both on the same queue cancel.
  always_comb begin
    for (int i = 0; i < QUEUE_NUM; i++) begin
      occ_d[i] = occ_next(occ_q[i],
                          admit && (i_cb_queue_sel == queue_id_t'(i)),
                          i_deq_valid && (i_deq_queue_id == queue_id_t'(i)) &&
                          (occ_q[i] != '0));
    end
  end

  // Drop and error status next-state.
  always_comb begin
    drop_pulse_d = drop;
    drop_cnt_d   = drop ? sat_inc(drop_cnt_q) : drop_cnt_q;
    underflow_d  = underflow_q || deq_at_zero;
  end

  // Occupancy and status registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < QUEUE_NUM; i++) occ_q[i] <= '0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_NUM; i++) occ_q[i] <= occ_d[i];
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
      underflow_q  <= underflow_d;
    end
  end

  // Nonempty vector decoded straight from registered occupancy.
  always_comb begin
    for (int i = 0; i < QUEUE_NUM; i++) o_queue_nonempty[i] = (occ_q[i] != '0);
  end

  assign o_drop_pulse    = drop_pulse_q;
  assign o_drop_cnt      = drop_cnt_q;
  assign o_err_underflow = underflow_q;

endmodule

// File: tb/tb_column_queue_admission.sv
// Bench for column_queue_admission: directed scenarios plus random traffic
// checked every cycle against a queue/array model of the admission rules.
module tb_column_queue_admission;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CAP   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    sel = '0;
  logic [DW-1:0] din = '0;
  logic          cbv = 1'b0;
  logic          wr_ready = 1'b0;
  logic          dv = 1'b0;
  logic [4:0]    did = '0;

  logic          o_wr_valid;
  logic [4:0]    o_wr_queue_id;
  logic [DW-1:0] o_wr_data;
  logic [31:0]   o_queue_nonempty;
  logic          o_drop_pulse;
  logic [15:0]   o_drop_cnt;
  logic          o_err_underflow;

  column_queue_admission #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .QUEUE_CAP  (CAP)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_cb_queue_sel   (sel),
    .i_cb_din         (din),
    .i_cb_dat_valid   (cbv),
    .o_wr_valid       (o_wr_valid),
    .o_wr_queue_id    (o_wr_queue_id),
    .o_wr_data        (o_wr_data),
    .i_wr_ready       (wr_ready),
    .i_deq_valid      (dv),
    .i_deq_queue_id   (did),
    .o_queue_nonempty (o_queue_nonempty),
    .o_drop_pulse     (o_drop_pulse),
    .o_drop_cnt       (o_drop_cnt),
    .o_err_underflow  (o_err_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_occ [32];
  logic [36:0] m_fifo [$];
  int          m_drop_cnt;
  bit          m_pulse;
  bit          m_uf;
  bit          m_adm;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_occ[i]) m_occ[i] = 0;
      m_fifo.delete();
      m_drop_cnt = 0;
      m_pulse = 0;
      m_uf = 0;
    end else begin
      m_adm = cbv && (m_occ[sel] < CAP) && (m_fifo.size() < DEPTH);
      if (m_fifo.size() > 0 && wr_ready) void'(m_fifo.pop_front());
      if (m_adm) m_fifo.push_back({sel, din});
      m_pulse = cbv && !m_adm;
      if (m_pulse && m_drop_cnt < 65535) m_drop_cnt++;
      if (dv) begin
        if (m_occ[did] == 0) m_uf = 1;
        else m_occ[did]--;
      end
      if (m_adm) m_occ[sel]++;
    end
  end

  function automatic logic [31:0] m_nonempty();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = (m_occ[i] != 0);
    return v;
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("wr_valid", o_wr_valid, m_fifo.size() != 0);
      if (m_fifo.size() != 0) begin
        check("wr_queue_id", o_wr_queue_id, m_fifo[0][36:32]);
        check("wr_data", o_wr_data, m_fifo[0][31:0]);
      end
      check("nonempty", o_queue_nonempty, m_nonempty());
      check("drop_pulse", o_drop_pulse, m_pulse);
      check("drop_cnt", o_drop_cnt, m_drop_cnt);
      check("underflow", o_err_underflow, m_uf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic strobe(input logic [4:0] s, input logic [DW-1:0] d);
    sel = s; din = d; cbv = 1'b1;
    cyc();
    cbv = 1'b0;
  endtask

  task automatic deq(input logic [4:0] id);
    did = id; dv = 1'b1;
    cyc();
    dv = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end

  int outs, pulses;

  initial begin
    // Reset state
    rst_n = 1'b0; wr_ready = 1'b1;
    idle(2);
    check("rst_valid", o_wr_valid, 1'b0);
    check("rst_nonempty", o_queue_nonempty, 32'h0);
    check("rst_drop_cnt", o_drop_cnt, 16'h0);
    check("rst_pulse", o_drop_pulse, 1'b0);
    check("rst_underflow", o_err_underflow, 1'b0);
    check("rst_data", o_wr_data, 32'h0);
    check("rst_qid", o_wr_queue_id, 5'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Single word
    strobe(5'b101_10, 32'hA5A5_0062);
    check("single_valid", o_wr_valid, 1'b1);
    check("single_qid", o_wr_queue_id, 5'd22);
    check("single_data", o_wr_data, 32'hA5A5_0062);
    check("single_nonempty22", o_queue_nonempty[22], 1'b1);
    cyc();
    check("single_popped", o_wr_valid, 1'b0);
    deq(5'd22);
    check("single_drained", o_queue_nonempty, 32'h0);

    // Cap limit on queue 3
    outs = 0; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      strobe(5'd3, 32'hC000_0000 + i);
      outs += int'(o_wr_valid);
      pulses += int'(o_drop_pulse);
      idle(2);
    end
    check("cap_outs", outs, 4);
    check("cap_pulses", pulses, 1);
    check("cap_drop_cnt", o_drop_cnt, 16'd1);
    deq(5'd3);
    strobe(5'd3, 32'hC000_0005);
    check("cap_readmit_valid", o_wr_valid, 1'b1);
    check("cap_readmit_pulse", o_drop_pulse, 1'b0);
    check("cap_readmit_cnt", o_drop_cnt, 16'd1);
    idle(2);
    for (int i = 0; i < 4; i++) deq(5'd3);
    check("cap_drained", o_queue_nonempty[3], 1'b0);

    // Backpressure
    wr_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      strobe(5'(8 + i), 32'hB000_0000 + i);
      check("bp_head", o_wr_data, 32'hB000_0000);
      idle(2);
      check("bp_head_stall", o_wr_data, 32'hB000_0000);
    end
    check("bp_drop_cnt", o_drop_cnt, 16'd3);
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_valid", o_wr_valid, 1'b1);
      check("bp_drain_data", o_wr_data, 32'hB000_0000 + k);
      cyc();
    end
    check("bp_empty", o_wr_valid, 1'b0);
    for (int i = 0; i < 4; i++) deq(5'(8 + i));
    check("bp_occ_clear", o_queue_nonempty, 32'h0);

    // Simultaneous admit and dequeue on queue 7
    strobe(5'd7, 32'h7000_0001); idle(2);
    strobe(5'd7, 32'h7000_0002); idle(2);
    sel = 5'd7; din = 32'h7000_0003; cbv = 1'b1; did = 5'd7; dv = 1'b1;
    cyc();
    cbv = 1'b0; dv = 1'b0;
    check("sim_model_occ2", m_occ[7], 2);
    check("sim_pulse_occ2", o_drop_pulse, 1'b0);
    idle(2);
    strobe(5'd7, 32'h7000_0004); idle(2);
    strobe(5'd7, 32'h7000_0005); idle(2);
    check("sim_model_cap", m_occ[7], CAP);
    sel = 5'd7; din = 32'h7000_0006; cbv = 1'b1; did = 5'd7; dv = 1'b1;
    cyc();
    cbv = 1'b0; dv = 1'b0;
    check("sim_cap_pulse", o_drop_pulse, 1'b1);
    check("sim_model_cap_m1", m_occ[7], CAP - 1);
    idle(2);
    for (int i = 0; i < CAP - 1; i++) deq(5'd7);
    check("sim_drained", o_queue_nonempty[7], 1'b0);
    check("sim_no_underflow", o_err_underflow, 1'b0);

    // Underflow
    deq(5'd0);
    check("uf_set", o_err_underflow, 1'b1);
    check("uf_occ0", o_queue_nonempty[0], 1'b0);
    idle(3);
    check("uf_sticky", o_err_underflow, 1'b1);

    // Reset mid-stream: bring drop count to 5 and buffer 3 words
    for (int i = 0; i < 5; i++) begin
      strobe(5'd3, 32'hD000_0000 + i);
      idle(2);
    end
    check("mid_drop5", o_drop_cnt, 16'd5);
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe(5'(20 + i), 32'hE000_0000 + i);
      idle(2);
    end
    check("mid_buffered", o_wr_valid, 1'b1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("mid_rst_valid", o_wr_valid, 1'b0);
    check("mid_rst_nonempty", o_queue_nonempty, 32'h0);
    check("mid_rst_drop_cnt", o_drop_cnt, 16'd0);
    check("mid_rst_underflow", o_err_underflow, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 499) != 0);
      cbv      = ($urandom_range(0, 2) == 0);
      sel      = 5'($urandom_range(0, 7));
      din      = $urandom;
      wr_ready = ($urandom_range(0, 3) != 0);
      dv       = ($urandom_range(0, 9) < 3);
      did      = 5'($urandom_range(0, 7));
      if (dv && cbv && did == sel && m_occ[sel] == 0) dv = 1'b0;
      cyc();
    end
    rst_n = 1'b1; cbv = 1'b0; dv = 1'b0; wr_ready = 1'b1;
    idle(DEPTH + 2);
    check("final_empty", o_wr_valid, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
